scalar_vec_scheduler: RTL and testbench

Round-robin scheduler that shares one COMBSIZE-lane fixed-point scalar×vector multiplier between NREQ requesters in the RLS datapath, e.g. gain-vector scaling and P-matrix row scaling. It owns the multiply lanes, the chunk sequencing and the result buffer. It accepts one job at a time via a request/grant handshake, processes the vector COMBSIZE elements per cycle, and signals completion with a one-cycle done pulse tagged with the requester ID.

---
 rtl/scalar_vec_scheduler.sv | 162 ++++++++++++++++
 tb/tb_scalar_vec_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_vec_scheduler.sv
// Round-robin share of one COMBSIZE-lane Q(FRAC) scalar x vector multiplier among NREQ requesters.
// Optional SCALAR_VEC_SATURATE_EN clamps each lane instead of wrapping; latency is NCHUNK+2 cycles per job.
module scalar_vec_scheduler #(
  parameter int WIDTH    = 32,
  parameter int SIZE_B   = 16,
  parameter int COMBSIZE = 4,
  parameter int FRAC     = 16,
  parameter int NREQ     = 2,
  parameter int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*WIDTH-1:0]          a_in,
  input  logic [NREQ*WIDTH*SIZE_B-1:0]   b_in,
  output logic [NREQ-1:0]                gnt,
  output logic                           busy,
  output logic                           done,
  output logic [ID_W-1:0]                done_id,
  output logic [WIDTH*SIZE_B-1:0]        y
);

  localparam int NCHUNK = SIZE_B / COMBSIZE;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef SCALAR_VEC_SATURATE_EN
  localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  function automatic logic [WIDTH-1:0] lane_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    prod    = $signed(a) * $signed(b);
    shifted = prod >>> FRAC;
`ifdef SCALAR_VEC_SATURATE_EN
    if (shifted > SAT_MAX) shifted = SAT_MAX;
    else if (shifted < SAT_MIN) shifted = SAT_MIN;
`endif
    return shifted[WIDTH-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q [SIZE_B];
  logic [WIDTH-1:0]   b_d [SIZE_B];
  logic [WIDTH-1:0]   y_q [SIZE_B];
  logic [WIDTH-1:0]   y_d [SIZE_B];
  logic [WIDTH-1:0]   b_lane [COMBSIZE];
  logic [WIDTH-1:0]   p_lane [COMBSIZE];

  // Lane operands are muxed by chunk first so only COMBSIZE multipliers exist.
  always_comb begin
    for (int k = 0; k < COMBSIZE; k++) begin
      b_lane[k] = '0;
      for (int c = 0; c < NCHUNK; c++) begin
        if (idx_q == IDX_W'(c)) b_lane[k] = b_q[c*COMBSIZE + k];
      end
      p_lane[k] = lane_mul(a_q, b_lane[k]);
    end
  end

  always_comb begin
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand_id;
    int              cand;

    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    found   = 1'b0;
    win     = '0;
    cand    = 0;
    cand_id = '0;

    // Search starts one past the last winner and wraps.
    for (int off = 1; off <= NREQ; off++) begin
      cand    = (int'(last_q) + off) % NREQ;
      cand_id = ID_W'(cand);
      if (!found && req[cand_id]) begin
        found = 1'b1;
        win   = cand_id;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = RUN;
          idx_d   = '0;
          gnt_d   = NREQ'(1) << win;
          last_d  = win;
          owner_d = win;
          for (int r = 0; r < NREQ; r++) begin
            if (win == ID_W'(r)) begin
              a_d = a_in[WIDTH*r +: WIDTH];
              for (int i = 0; i < SIZE_B; i++) b_d[i] = b_in[WIDTH*SIZE_B*r + WIDTH*i +: WIDTH];
            end
          end
        end
      end
      RUN: begin
        for (int c = 0; c < NCHUNK; c++) begin
          if (idx_q == IDX_W'(c)) begin
            for (int k = 0; k < COMBSIZE; k++) y_d[c*COMBSIZE + k] = p_lane[k];
          end
        end
        if (idx_q == IDX_W'(NCHUNK-1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      last_q  <= ID_W'(NREQ-1);
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '{default: '0};
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    gnt     = gnt_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    done_id = owner_q;
    for (int i = 0; i < SIZE_B; i++) y[WIDTH*i +: WIDTH] = y_q[i];
  end

endmodule

// File: tb/tb_scalar_vec_scheduler.sv
// Scoreboard bench for scalar_vec_scheduler: directed jobs push expected grants/results, a negedge monitor checks them.
module tb_scalar_vec_scheduler;

  localparam int WIDTH = 32, SIZE_B = 16, COMBSIZE = 4, FRAC = 16, NREQ = 2, ID_W = 1;
  localparam int NCHUNK = SIZE_B / COMBSIZE;
  localparam int YW = WIDTH * SIZE_B;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*YW-1:0]   b_in;
  logic [NREQ-1:0]      gnt;
  logic                 busy, done;
  logic [ID_W-1:0]      done_id;
  logic [YW-1:0]        y;

  scalar_vec_scheduler #(
    .WIDTH(WIDTH), .SIZE_B(SIZE_B), .COMBSIZE(COMBSIZE), .FRAC(FRAC), .NREQ(NREQ), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .y(y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0] exp_gnt_q[$];
  int              exp_id_q[$];
  logic [YW-1:0]   exp_y_q[$];

  task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: pops expectations whenever the DUT grants or completes.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (gnt !== '0) begin
        if (exp_gnt_q.size() == 0) fail("unexpected_gnt", $sformatf("gnt=%b required 00", gnt));
        else chk("gnt", YW'(gnt), YW'(exp_gnt_q.pop_front()));
        gnt_cyc = cyc;
      end
      if (done === 1'b1) begin
        if (exp_id_q.size() == 0) fail("unexpected_done", "done=1 required 0");
        else begin
          chk("done_id", YW'(done_id), YW'(exp_id_q.pop_front()));
          chk("y", y, exp_y_q.pop_front());
          chk("gnt_to_done", YW'(cyc - gnt_cyc), YW'(NCHUNK));
        end
      end
    end
  end

  task automatic wait_gnt(output int c);
    c = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        c = cyc;
        return;
      end
    end
    fail("gnt_timeout", "no gnt within 30 cycles, required one");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 30; n++) begin
      if (busy === 1'b0) return;
      @(negedge clk);
    end
    fail("busy_timeout", "busy still 1 after 30 cycles, required 0");
  endtask

  task automatic set_a(input int r, input logic [WIDTH-1:0] v);
    a_in[WIDTH*r +: WIDTH] = v;
  endtask

  task automatic set_b(input int r, input int i, input logic [WIDTH-1:0] v);
    b_in[YW*r + WIDTH*i +: WIDTH] = v;
  endtask

  task automatic push_job(input int r, input logic [YW-1:0] ey);
    exp_gnt_q.push_back(NREQ'(1) << r);
    exp_id_q.push_back(r);
    exp_y_q.push_back(ey);
  endtask

  task automatic run_job(input int r, input logic [YW-1:0] ey);
    int c;
    push_job(r, ey);
    req[r] = 1'b1;
    wait_gnt(c);
    req[r] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [YW-1:0] ey;
    logic [YW-1:0] ey1;
    int c0, c1;
    int gc[4];

    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt", YW'(gnt), '0);
    chk("rst_busy", YW'(busy), '0);
    chk("rst_done", YW'(done), '0);
    chk("rst_done_id", YW'(done_id), '0);
    chk("rst_y", y, '0);

    // Single job: 2.0 * (i<<16)
    set_a(0, 32'h0002_0000);
    for (int i = 0; i < SIZE_B; i++) set_b(0, i, WIDTH'(i) << 16);
    for (int i = 0; i < SIZE_B; i++) ey[WIDTH*i +: WIDTH] = WIDTH'(2*i) << 16;
    run_job(0, ey);
    chk("y15", YW'(y[WIDTH*15 +: WIDTH]), YW'(32'h001E_0000));

    // Negative scalar via requester 1: -1.5 * 1.0
    set_a(1, 32'hFFFE_8000);
    for (int i = 0; i < SIZE_B; i++) set_b(1, i, 32'h0001_0000);
    for (int i = 0; i < SIZE_B; i++) ey[WIDTH*i +: WIDTH] = 32'hFFFE_8000;
    run_job(1, ey);

    // Overflow both directions
    set_a(0, 32'h7FFF_0000);
    for (int i = 0; i < SIZE_B; i++) set_b(0, i, 32'h0);
    set_b(0, 0, 32'h0002_0000);
    set_b(0, 1, 32'hFFFE_0000);
    ey = '0;
`ifdef SCALAR_VEC_SATURATE_EN
    ey[WIDTH*0 +: WIDTH] = 32'h7FFF_FFFF;
    ey[WIDTH*1 +: WIDTH] = 32'h8000_0000;
`else
    ey[WIDTH*0 +: WIDTH] = 32'hFFFE_0000;
    ey[WIDTH*1 +: WIDTH] = 32'h0002_0000;
`endif
    run_job(0, ey);

    // Late request: requester 1 raised during requester 0's RUN; r0 operands trashed after grant
    set_a(0, 32'h0001_0000);
    for (int i = 0; i < SIZE_B; i++) set_b(0, i, WIDTH'(i+1) << 16);
    for (int i = 0; i < SIZE_B; i++) ey[WIDTH*i +: WIDTH] = WIDTH'(i+1) << 16;
    set_a(1, 32'h0000_8000);
    for (int i = 0; i < SIZE_B; i++) set_b(1, i, 32'h0004_0000);
    for (int i = 0; i < SIZE_B; i++) ey1[WIDTH*i +: WIDTH] = 32'h0002_0000;
    push_job(0, ey);
    push_job(1, ey1);
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    set_a(0, 32'hDEAD_BEEF);
    for (int i = 0; i < SIZE_B; i++) set_b(0, i, 32'hBAD0_0000);
    repeat (2) @(negedge clk);
    req[1] = 1'b1;
    wait_gnt(c1);
    req = 2'b00;
    chk("late_gnt_spacing", YW'(c1 - c0), YW'(NCHUNK + 2));
    wait_idle();

    // Reset two cycles after grant aborts the job
    exp_gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", YW'(busy), '0);
    chk("abort_done", YW'(done), '0);
    chk("abort_y", y, '0);

    // Round-robin with both requests held
    set_a(0, 32'h0001_0000);
    for (int i = 0; i < SIZE_B; i++) set_b(0, i, WIDTH'(i) << 16);
    for (int i = 0; i < SIZE_B; i++) ey[WIDTH*i +: WIDTH] = WIDTH'(i) << 16;
    set_a(1, 32'h0003_0000);
    for (int i = 0; i < SIZE_B; i++) set_b(1, i, 32'h0000_8000);
    for (int i = 0; i < SIZE_B; i++) ey1[WIDTH*i +: WIDTH] = 32'h0001_8000;
    push_job(0, ey);
    push_job(1, ey1);
    push_job(0, ey);
    push_job(1, ey1);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(gc[k]);
      if (k == 3) req = 2'b00;
      if (k > 0) chk("rr_spacing", YW'(gc[k] - gc[k-1]), YW'(NCHUNK + 2));
    end
    wait_idle();

    repeat (10) @(negedge clk);
    chk("pending_gnt", YW'(exp_gnt_q.size()), '0);
    chk("pending_done", YW'(exp_id_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
